// File: rtl/board_io_pkg.sv
// Shared widths, FSM encoding and helpers for the board-side operand nibble interface.
package board_io_pkg;

  localparam int unsigned NIB_W = 4;
  localparam int unsigned SEL_W = 3;

  typedef enum logic {
    EDIT = 1'b0,
    HOLD = 1'b1
  } ldr_state_t;

  // Saturating 8-bit increment for event counters.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter and a rising-edge press pulse.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic             sync_ff1;
  logic             sync_ff2;
  logic             stable;
  logic             stable_q;
  logic [CNT_W-1:0] cnt;

  // A level change is accepted only after DEB_CYCLES consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_ff1 <= 1'b0;
      sync_ff2 <= 1'b0;
      stable   <= 1'b0;
      stable_q <= 1'b0;
      cnt      <= '0;
    end else begin
      sync_ff1 <= raw;
      sync_ff2 <= sync_ff1;
      stable_q <= stable;
      if (sync_ff2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
        stable <= sync_ff2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign press = stable & ~stable_q;

endmodule

// File: rtl/operand_nibble_loader.sv
// Assembles an operand nibble-by-nibble from switches and offers it to the shifter over valid/ready.
module operand_nibble_loader
  import board_io_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NIB_W-1:0]  nibble_in,
  input  logic [SEL_W-1:0]  nibble_sel,
  input  logic              load_btn,
  input  logic              commit_btn,
  output logic [DATA_W-1:0] operand,
  output logic              operand_valid,
  input  logic              operand_ready,
  output logic [NIB_W-1:0]  echo_nibble,
  output logic [7:0]        drop_cnt
);

  localparam int unsigned NIBS = DATA_W / NIB_W;

  logic              load_press;
  logic              commit_press;
  logic              sel_ok;
  logic              load_wr;
  logic [DATA_W-1:0] shadow;
  logic [DATA_W-1:0] shadow_nxt;
  ldr_state_t        state;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_load_deb (
    .clk   (clk),
    .rst   (rst),
    .raw   (load_btn),
    .press (load_press)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_commit_deb (
    .clk   (clk),
    .rst   (rst),
    .raw   (commit_btn),
    .press (commit_press)
  );

  // Selector values beyond the last nibble are silently ignored.
  if (NIBS >= (1 << SEL_W)) begin : g_sel_full
    assign sel_ok = 1'b1;
  end else begin : g_sel_part
    assign sel_ok = (32'(nibble_sel) < NIBS);
  end

  assign load_wr = load_press & sel_ok;

  // Next shadow value; also feeds the operand so a same-cycle load is committed.
  always_comb begin
    shadow_nxt = shadow;
    if (load_wr) begin
      for (int unsigned i = 0; i < NIBS; i++) begin
        if (32'(nibble_sel) == i) begin
          shadow_nxt[i*NIB_W +: NIB_W] = nibble_in;
        end
      end
    end
  end

  always_comb begin
    echo_nibble = '0;
    for (int unsigned i = 0; i < NIBS; i++) begin
      if (32'(nibble_sel) == i) begin
        echo_nibble = shadow[i*NIB_W +: NIB_W];
      end
    end
  end

  // EDIT/HOLD handshake FSM with shadow, operand and drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= EDIT;
      shadow        <= '0;
      operand       <= '0;
      operand_valid <= 1'b0;
      drop_cnt      <= '0;
    end else begin
      shadow <= shadow_nxt;
      case (state)
        EDIT: begin
          if (commit_press) begin
            operand       <= shadow_nxt;
            operand_valid <= 1'b1;
            state         <= HOLD;
          end
        end
        HOLD: begin
          if (commit_press) begin
            drop_cnt <= sat_inc8(drop_cnt);
          end
          if (operand_valid && operand_ready) begin
            operand_valid <= 1'b0;
            state         <= EDIT;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_operand_nibble_loader.sv
// Self-checking bench for operand_nibble_loader: directed vectors, corner sequences and a random run against a model.
`timescale 1ns/1ps
module tb_operand_nibble_loader;

  logic        clk;
  logic        rst;
  logic [3:0]  nibble_in;
  logic [2:0]  nibble_sel;
  logic        load_btn;
  logic        commit_btn;
  logic [31:0] operand;
  logic        operand_valid;
  logic        operand_ready;
  logic [3:0]  echo_nibble;
  logic [7:0]  drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  logic [3:0]  m_nib [8];
  logic [31:0] m_operand;
  logic        m_busy;
  int          m_drop;

  typedef struct {
    logic [3:0]  nib;
    logic [2:0]  sel;
    logic [31:0] exp_shadow;
  } vec_t;

  vec_t vecs [8];

  operand_nibble_loader #(.DATA_W(32), .DEB_CYCLES(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .nibble_in     (nibble_in),
    .nibble_sel    (nibble_sel),
    .load_btn      (load_btn),
    .commit_btn    (commit_btn),
    .operand       (operand),
    .operand_valid (operand_valid),
    .operand_ready (operand_ready),
    .echo_nibble   (echo_nibble),
    .drop_cnt      (drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_shadow();
    logic [31:0] v;
    for (int i = 0; i < 8; i++) v[i*4 +: 4] = m_nib[i];
    return v;
  endfunction

  // Sweeps the selector and gathers the shadow through the LED echo.
  task automatic read_shadow(output logic [31:0] v);
    for (int i = 0; i < 8; i++) begin
      nibble_sel = 3'(i);
      #1;
      v[i*4 +: 4] = echo_nibble;
    end
  endtask

  task automatic model_press(input logic do_load, input logic do_commit,
                             input logic [3:0] nib, input logic [2:0] sel);
    if (do_load) m_nib[sel] = nib;
    if (do_commit) begin
      if (!m_busy) begin
        m_operand = model_shadow();
        m_busy    = 1'b1;
      end else begin
        m_drop = (m_drop < 255) ? m_drop + 1 : 255;
      end
    end
  endtask

  // Clean hold long enough to debounce, then a clean release.
  task automatic press(input logic do_load, input logic do_commit,
                       input logic [3:0] nib, input logic [2:0] sel);
    @(negedge clk);
    nibble_in  = nib;
    nibble_sel = sel;
    load_btn   = do_load;
    commit_btn = do_commit;
    repeat (20) @(negedge clk);
    load_btn   = 1'b0;
    commit_btn = 1'b0;
    repeat (22) @(negedge clk);
    model_press(do_load, do_commit, nib, sel);
  endtask

  task automatic pulse_ready();
    @(negedge clk);
    operand_ready = 1'b1;
    @(negedge clk);
    operand_ready = 1'b0;
    @(negedge clk);
    if (m_busy) m_busy = 1'b0;
  endtask

  task automatic check_model(input string tag);
    logic [31:0] sh;
    check({tag, "_operand"}, operand, m_operand);
    check({tag, "_valid"}, 32'(operand_valid), 32'(m_busy));
    check({tag, "_drop"}, 32'(drop_cnt), 32'(m_drop));
    read_shadow(sh);
    check({tag, "_shadow"}, sh, model_shadow());
  endtask

  initial begin
    logic [31:0] sh;
    logic [31:0] held_op;
    int          op;

    vecs[0] = '{4'h1, 3'd0, 32'h00000A01};
    vecs[1] = '{4'h2, 3'd1, 32'h00000A21};
    vecs[2] = '{4'h3, 3'd2, 32'h00000321};
    vecs[3] = '{4'h4, 3'd3, 32'h00004321};
    vecs[4] = '{4'h5, 3'd4, 32'h00054321};
    vecs[5] = '{4'h6, 3'd5, 32'h00654321};
    vecs[6] = '{4'h7, 3'd6, 32'h07654321};
    vecs[7] = '{4'h8, 3'd7, 32'h87654321};

    for (int i = 0; i < 8; i++) m_nib[i] = 4'h0;
    m_operand = '0;
    m_busy    = 1'b0;
    m_drop    = 0;

    rst = 1'b1; nibble_in = '0; nibble_sel = '0;
    load_btn = 1'b0; commit_btn = 1'b0; operand_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_operand", operand, 32'h0);
    check("rst_valid", 32'(operand_valid), 32'h0);
    check("rst_drop", 32'(drop_cnt), 32'h0);
    check("rst_echo", 32'(echo_nibble), 32'h0);
    rst = 1'b0;

    // Reset during a running count must restart it; too few highs remain afterwards.
    nibble_in = 4'h5; nibble_sel = 3'd0; load_btn = 1'b1;
    repeat (12) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    load_btn = 1'b0;
    repeat (30) @(negedge clk);
    read_shadow(sh);
    check("rst_mid_debounce", sh, 32'h0);

    // Exact write latency: raw first sampled at edge 1, write at edge 19.
    @(negedge clk);
    nibble_in = 4'hA; nibble_sel = 3'd2; load_btn = 1'b1;
    repeat (18) @(posedge clk);
    #1 check("load_before_edge19", 32'(echo_nibble), 32'h0);
    @(posedge clk);
    #1 check("load_at_edge19", 32'(echo_nibble), 32'hA);
    @(negedge clk);
    @(negedge clk);
    load_btn = 1'b0;
    repeat (25) @(negedge clk);
    m_nib[2] = 4'hA;
    read_shadow(sh);
    check("load_shadow", sh, 32'h00000A00);

    // Bounce shorter than the debounce window must not write.
    @(negedge clk);
    nibble_in = 4'hF; nibble_sel = 3'd2;
    for (int i = 0; i < 10; i++) begin
      load_btn = ~load_btn;
      repeat (3) @(negedge clk);
    end
    load_btn = 1'b0;
    repeat (25) @(negedge clk);
    read_shadow(sh);
    check("bounce_shadow", sh, 32'h00000A00);

    for (int i = 0; i < 8; i++) begin
      press(1'b1, 1'b0, vecs[i].nib, vecs[i].sel);
      read_shadow(sh);
      check($sformatf("fill_%0d", i), sh, vecs[i].exp_shadow);
    end

    press(1'b0, 1'b1, 4'h0, 3'd0);
    check("commit_operand", operand, 32'h87654321);
    check("commit_valid", 32'(operand_valid), 32'h1);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(operand_valid), 32'h1);
      check("hold_operand", operand, 32'h87654321);
    end
    @(negedge clk);
    operand_ready = 1'b1;
    @(posedge clk);
    #1 check("handshake_valid", 32'(operand_valid), 32'h0);
    @(negedge clk);
    operand_ready = 1'b0;
    m_busy = 1'b0;
    check("handshake_operand_kept", operand, 32'h87654321);

    // Commits while busy are dropped; loads only reach the shadow.
    press(1'b0, 1'b1, 4'h0, 3'd0);
    press(1'b0, 1'b1, 4'h0, 3'd0);
    press(1'b0, 1'b1, 4'h0, 3'd0);
    check("drop_two", 32'(drop_cnt), 32'd2);
    check("drop_operand", operand, 32'h87654321);
    press(1'b1, 1'b0, 4'hF, 3'd0);
    read_shadow(sh);
    check("hold_load_shadow", sh, 32'h8765432F);
    check("hold_load_operand", operand, 32'h87654321);
    pulse_ready();
    check_model("after_hold");

    // Simultaneous load and commit in EDIT commits the new nibble.
    press(1'b1, 1'b1, 4'hC, 3'd7);
    check("bypass_nibble", 32'(operand[31:28]), 32'hC);
    check("bypass_operand", operand, 32'hC765432F);
    check_model("bypass");
    pulse_ready();

    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 3);
      case (op)
        0: press(1'b1, 1'b0, 4'($urandom), 3'($urandom));
        1: press(1'b0, 1'b1, 4'($urandom), 3'($urandom));
        2: press(1'b1, 1'b1, 4'($urandom), 3'($urandom));
        default: pulse_ready();
      endcase
      check_model($sformatf("rand_%0d", n));
    end

    // Drop counter saturation.
    if (!m_busy) press(1'b0, 1'b1, 4'h0, 3'd0);
    held_op = m_operand;
    for (int n = 0; n < 258; n++) press(1'b0, 1'b1, 4'h0, 3'd0);
    check("drop_saturated", 32'(drop_cnt), 32'd255);
    check("sat_operand", operand, held_op);
    check_model("saturate");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
